deep_seq_step_chain: RTL

- Sequential, one-step-per-cycle evaluator of the team's fixed 20-operation arithmetic step table. The table is applied twice, for up to 40 steps.
- It is the multi-cycle counterpart of our deep combinational assign chains. It replaces a 40-deep combinational path with an iterative datapath behind valid/ready handshakes.
- A run-time step limit lets verification observe any intermediate chain value.

---
 rtl/deep_seq_step_chain.sv | 89 ++++++++
 1 files changed

// File: rtl/deep_seq_step_chain.sv
// deep_seq_step_chain: one-step-per-cycle evaluator of the 20-op step table applied up to MAX_STEPS times
module deep_seq_step_chain #(
  parameter int WIDTH = 16,
  parameter int MAX_STEPS = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dssc_in_valid,
  output logic             dssc_in_ready,
  input  logic [WIDTH-1:0] dssc_start_val,
  input  logic [5:0]       dssc_step_limit,
  output logic             dssc_out_valid,
  input  logic             dssc_out_ready,
  output logic [WIDTH-1:0] dssc_end_val,
  output logic [5:0]       dssc_step_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [5:0] LIM_MAX = 6'(MAX_STEPS);
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, step_val;
  logic [5:0] lim_q, lim_d, cnt_q, cnt_d, lim_in;
  logic [4:0] j;
  assign lim_in = dssc_step_limit > LIM_MAX ? LIM_MAX : dssc_step_limit;
  assign j = 5'(cnt_q % 6'd20);
  always_comb begin
    step_val = acc_q;
    case (j)
      5'd0:  step_val = acc_q + WIDTH'(1);
      5'd1:  step_val = acc_q * WIDTH'(2);
      5'd2:  step_val = acc_q - WIDTH'(3);
      5'd3:  step_val = acc_q ^ WIDTH'(4);
      5'd4:  step_val = acc_q | WIDTH'(5);
      5'd5:  step_val = acc_q & WIDTH'(6);
      5'd6:  step_val = acc_q + WIDTH'(7);
      5'd7:  step_val = acc_q - WIDTH'(8);
      5'd8:  step_val = acc_q ^ WIDTH'(9);
      5'd9:  step_val = acc_q | WIDTH'(10);
      5'd10: step_val = acc_q & WIDTH'(11);
      5'd11: step_val = acc_q + WIDTH'(12);
      5'd12: step_val = acc_q - WIDTH'(13);
      5'd13: step_val = acc_q ^ WIDTH'(14);
      5'd14: step_val = acc_q | WIDTH'(15);
      5'd15: step_val = acc_q + WIDTH'(16);
      5'd16: step_val = acc_q * WIDTH'(17);
      5'd17: step_val = acc_q - WIDTH'(18);
      5'd18: step_val = acc_q ^ WIDTH'(19);
      5'd19: step_val = acc_q | WIDTH'(20);
      default: step_val = acc_q;
    endcase
  end
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    lim_d = lim_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (dssc_in_valid) begin
        acc_d = dssc_start_val;
        lim_d = lim_in;
        cnt_d = '0;
        state_d = lim_in == '0 ? DONE : RUN;
      end
      RUN: begin
        acc_d = step_val;
        cnt_d = cnt_q + 6'd1;
        state_d = cnt_q + 6'd1 == lim_q ? DONE : RUN;
      end
      DONE: state_d = dssc_out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      lim_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      lim_q <= lim_d;
      cnt_q <= cnt_d;
    end
  end
  assign dssc_in_ready = state_q == IDLE;
  assign dssc_out_valid = state_q == DONE;
  assign dssc_end_val = acc_q;
  assign dssc_step_cnt = cnt_q;
endmodule
